// File: rtl/mux_rr_n_if.sv
// mux_rr_n_if: handshake bundle for mux_rr_n.
//   mode      : 0 = explicit select, 1 = round-robin
//   sel       : channel index used when mode = 0
//   in_data   : N packed channels, channel k in [k*WIDTH +: WIDTH]
//   in_valid  : per-channel valid
//   in_ready  : per-channel ready, at most one bit high
//   out_data  : registered selected word
//   out_ch    : registered index of the channel that supplied out_data
//   out_valid : output register holds a word
//   out_ready : downstream accepts the word
//   sel_err   : registered one-cycle pulse for an out-of-range sel in mode 0
// Modport slave is the mux side, master is the driver/consumer side.
interface mux_rr_n_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4,
  parameter int unsigned SEL_W = 2
) ();

  logic                 mode;
  logic [SEL_W-1:0]     sel;
  logic [N*WIDTH-1:0]   in_data;
  logic [N-1:0]         in_valid;
  logic [N-1:0]         in_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SEL_W-1:0]     out_ch;
  logic                 out_valid;
  logic                 out_ready;
  logic                 sel_err;

  modport slave (
    input  mode,
    input  sel,
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_ch,
    output out_valid,
    input  out_ready,
    output sel_err
  );

  modport master (
    output mode,
    output sel,
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_ch,
    input  out_valid,
    output out_ready,
    input  sel_err
  );

endinterface

// File: rtl/mux_rr_n.sv
// mux_rr_n: N-channel multiplexer with a single-entry registered output.
// Arbitration is either an explicit channel select (mode = 0) or round-robin
// starting from an internal pointer (mode = 1).
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : mux_rr_n_if slave modport (see interface file for signal list)
module mux_rr_n #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4,
  parameter int unsigned SEL_W = 2
) (
  input logic          clk,
  input logic          rst,
  mux_rr_n_if.slave    bus
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             sel_err_q, sel_err_d;

  logic             sel_ok;
  logic             load;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  logic [N-1:0]     in_ready;
  logic             xfer;
  logic [WIDTH-1:0] grant_data;

  // Widen by one bit so N = 2**SEL_W still compares correctly.
  assign sel_ok = ({1'b0, bus.sel} < (SEL_W+1)'(N));

  // Output register accepts a new word when empty or being drained.
  assign load = !out_valid_q || bus.out_ready;

  // Grant selection. Round-robin rotates the valids so that bit i of rot is
  // channel (ptr + i) mod N; only the first N rotated bits are searched, so
  // indices >= N never appear.
  always_comb begin
    logic [2*N-1:0] rot;
    logic [SEL_W:0] sum;
    grant_vld = 1'b0;
    grant_idx = '0;
    rot       = {bus.in_valid, bus.in_valid} >> ptr_q;
    sum       = '0;
    if (!bus.mode) begin
      grant_vld = sel_ok;
      grant_idx = bus.sel;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!grant_vld && rot[i]) begin
          sum = {1'b0, ptr_q} + (SEL_W+1)'(i);
          if (sum >= (SEL_W+1)'(N)) begin
            sum = sum - (SEL_W+1)'(N);
          end
          grant_vld = 1'b1;
          grant_idx = sum[SEL_W-1:0];
        end
      end
    end
  end

  // Ready only to the granted channel, only when the output can load.
  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < N; i++) begin
      in_ready[i] = grant_vld && load && !rst && (grant_idx == SEL_W'(i));
    end
  end

  assign xfer = |(bus.in_valid & in_ready);

  always_comb begin
    grant_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_idx == SEL_W'(i)) begin
        grant_data = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    sel_err_d   = !bus.mode && !sel_ok;

    if (xfer) begin
      out_data_d  = grant_data;
      out_ch_d    = grant_idx;
      out_valid_d = 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    // Pointer advances past the winner on round-robin transfers only.
    if (xfer && bus.mode) begin
      ptr_d = (grant_idx == SEL_W'(N - 1)) ? '0 : grant_idx + SEL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
      sel_err_q   <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sel_err   = sel_err_q;

  a_ready_onehot: assert property (@(posedge clk) $onehot0(in_ready));

  a_ptr_range: assert property (@(posedge clk) disable iff (rst)
    ({1'b0, ptr_q} < (SEL_W+1)'(N)));

  a_stall_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid_q && !bus.out_ready) |=> ($stable(out_data_q) && $stable(out_ch_q)));

endmodule

// File: tb/tb_mux_rr_n.sv
module tb_mux_rr_n;

  localparam int unsigned W  = 32;
  localparam int unsigned N  = 4;
  localparam int unsigned SW = 2;

  logic clk = 1'b0;
  logic rst;
  logic rst3;

  always #5 clk = ~clk;

  mux_rr_n_if #(.WIDTH(W), .N(N), .SEL_W(SW)) bus ();
  mux_rr_n #(.WIDTH(W), .N(N), .SEL_W(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mux_rr_n_if #(.WIDTH(8), .N(3), .SEL_W(2)) bus3 ();
  mux_rr_n #(.WIDTH(8), .N(3), .SEL_W(2)) dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (bus3)
  );

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] iv;
    logic       ordy;
    logic [3:0] exp_ir;
    logic       exp_ov;
    logic [1:0] exp_ch;
  } vec_t;

  vec_t vecs[14];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic logic [31:0] d4(input logic [1:0] ch);
    case (ch)
      2'd0:    return 32'h1111_1111;
      2'd1:    return 32'h2222_2222;
      2'd2:    return 32'hA5A5_A5A5;
      default: return 32'h4444_4444;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, check ready combinationally, then check the
  // registered outputs just after the rising edge.
  task automatic step(input string name, input logic r, input logic mode, input logic [1:0] sel,
                      input logic [3:0] iv, input logic ordy, input logic [3:0] exp_ir,
                      input logic exp_ov, input logic [1:0] exp_ch, input logic exp_err);
    @(negedge clk);
    rst           = r;
    bus.mode      = mode;
    bus.sel       = sel;
    bus.in_valid  = iv;
    bus.out_ready = ordy;
    #1;
    chk({name, ".in_ready"}, 64'(bus.in_ready), 64'(exp_ir));
    @(posedge clk);
    #1;
    chk({name, ".out_valid"}, 64'(bus.out_valid), 64'(exp_ov));
    if (exp_ov) begin
      chk({name, ".out_ch"}, 64'(bus.out_ch), 64'(exp_ch));
      chk({name, ".out_data"}, 64'(bus.out_data), 64'(d4(exp_ch)));
    end
    chk({name, ".sel_err"}, 64'(bus.sel_err), 64'(exp_err));
  endtask

  task automatic step3(input string name, input logic r, input logic mode, input logic [1:0] sel,
                       input logic [2:0] iv, input logic ordy, input logic [2:0] exp_ir,
                       input logic exp_ov, input logic [1:0] exp_ch, input logic exp_err);
    @(negedge clk);
    rst3           = r;
    bus3.mode      = mode;
    bus3.sel       = sel;
    bus3.in_valid  = iv;
    bus3.out_ready = ordy;
    #1;
    chk({name, ".in_ready"}, 64'(bus3.in_ready), 64'(exp_ir));
    @(posedge clk);
    #1;
    chk({name, ".out_valid"}, 64'(bus3.out_valid), 64'(exp_ov));
    if (exp_ov) begin
      chk({name, ".out_ch"}, 64'(bus3.out_ch), 64'(exp_ch));
      chk({name, ".out_data"}, 64'(bus3.out_data), 64'(8'h10 + 8'(exp_ch)));
    end
    chk({name, ".sel_err"}, 64'(bus3.sel_err), 64'(exp_err));
  endtask

  initial begin
    logic [1:0] rr_ch;

    //           mode sel   iv       ordy  exp_ir   ov    ch
    vecs[0]  = '{1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
    vecs[1]  = '{1'b0, 2'd1, 4'b0000, 1'b1, 4'b0010, 1'b0, 2'd0};
    vecs[2]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
    vecs[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
    vecs[4]  = '{1'b0, 2'd3, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3};
    vecs[5]  = '{1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1};
    vecs[6]  = '{1'b1, 2'd0, 4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0};
    vecs[7]  = '{1'b1, 2'd0, 4'b0011, 1'b0, 4'b0000, 1'b1, 2'd0};
    vecs[8]  = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0};
    vecs[9]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
    vecs[10] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
    vecs[11] = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3};
    vecs[12] = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0};
    vecs[13] = '{1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0};

    rst            = 1'b1;
    bus.mode       = 1'b0;
    bus.sel        = 2'd0;
    bus.in_valid   = 4'hF;
    bus.out_ready  = 1'b1;
    bus.in_data    = {d4(2'd3), d4(2'd2), d4(2'd1), d4(2'd0)};
    rst3           = 1'b1;
    bus3.mode      = 1'b0;
    bus3.sel       = 2'd0;
    bus3.in_valid  = 3'b000;
    bus3.out_ready = 1'b1;
    bus3.in_data   = {8'h12, 8'h11, 8'h10};

    // Reset: ready low while rst, registers cleared.
    step("reset", 1'b1, 1'b0, 2'd0, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0);
    chk("reset.out_data", 64'(bus.out_data), 64'd0);
    chk("reset.out_ch", 64'(bus.out_ch), 64'd0);

    for (int i = 0; i < 14; i++) begin
      step($sformatf("vec%0d", i), 1'b0, vecs[i].mode, vecs[i].sel, vecs[i].iv, vecs[i].ordy,
           vecs[i].exp_ir, vecs[i].exp_ov, vecs[i].exp_ch, 1'b0);
    end

    // Backpressure: word held for three stalled cycles, next word follows at once.
    step("bp_load", 1'b0, 1'b0, 2'd1, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step($sformatf("bp_stall%0d", i), 1'b0, 1'b0, 2'd3, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b0);
    end
    step("bp_release", 1'b0, 1'b0, 2'd3, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b0);

    // Select-mode transfers above left ptr at 1.
    step("ptr_keep", 1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0);

    // Mid-stream reset with ptr = 2 and a held word.
    step("rst_mid", 1'b1, 1'b1, 2'd0, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0);
    chk("rst_mid.out_data", 64'(bus.out_data), 64'd0);

    // Full round-robin from ptr = 0 with no gaps.
    for (int i = 0; i < 8; i++) begin
      rr_ch = 2'(i);
      step($sformatf("rr%0d", i), 1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'(1 << rr_ch), 1'b1,
           rr_ch, 1'b0);
    end

    // N = 3 instance: wrap skips index 3, out-of-range select.
    step3("n3_rst", 1'b1, 1'b0, 2'd0, 3'b000, 1'b1, 3'b000, 1'b0, 2'd0, 1'b0);
    step3("n3_rr0", 1'b0, 1'b1, 2'd0, 3'b111, 1'b1, 3'b001, 1'b1, 2'd0, 1'b0);
    step3("n3_rr1", 1'b0, 1'b1, 2'd0, 3'b111, 1'b1, 3'b010, 1'b1, 2'd1, 1'b0);
    step3("n3_rr2", 1'b0, 1'b1, 2'd0, 3'b111, 1'b1, 3'b100, 1'b1, 2'd2, 1'b0);
    step3("n3_rr3", 1'b0, 1'b1, 2'd0, 3'b111, 1'b1, 3'b001, 1'b1, 2'd0, 1'b0);
    step3("n3_err_hold", 1'b0, 1'b0, 2'd3, 3'b111, 1'b0, 3'b000, 1'b1, 2'd0, 1'b1);
    step3("n3_err_drain", 1'b0, 1'b0, 2'd3, 3'b111, 1'b1, 3'b000, 1'b0, 2'd0, 1'b1);
    step3("n3_sel2", 1'b0, 1'b0, 2'd2, 3'b100, 1'b1, 3'b100, 1'b1, 2'd2, 1'b0);
    step3("n3_ptr1", 1'b0, 1'b1, 2'd0, 3'b010, 1'b1, 3'b010, 1'b1, 2'd1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_rr_n.md
MUX_RR_N -- requirements
Module: mux_rr_n

Interface
REQ-001 Parameter WIDTH, default 32, sets the data width per channel.
REQ-002 Parameter N, default 4, sets the number of input channels, legal range 2..16.
REQ-003 Parameter SEL_W, default 2, sets the select width, equal to clog2(N).
REQ-004 clk  input  1  is the single clock; all state changes on the rising edge.
REQ-005 rst  input  1  is a synchronous, active-high reset.
REQ-006 mode  input  1  selects arbitration: 0 = explicit select, 1 = round-robin.
REQ-007 sel  input  SEL_W  is the channel index used when mode=0.
REQ-008 in_data  input  N*WIDTH  carries channel k in bits [k*WIDTH +: WIDTH].
REQ-009 in_valid  input  N  is the per-channel valid.
REQ-010 in_ready  output  N  is the per-channel ready; at most one bit is high per cycle.
REQ-011 out_data  output  WIDTH  is the registered selected data.
REQ-012 out_ch  output  SEL_W  is the registered index of the channel that supplied out_data.
REQ-013 out_valid  output  1  is high when the output register holds data.
REQ-014 out_ready  input  1  indicates the downstream consumer accepts data.
REQ-015 sel_err  output  1  is a registered one-cycle pulse when mode=0 and sel>=N.

Function
REQ-016 The block shall contain a single-entry output register; load = ~out_valid | out_ready.
REQ-017 Grant in mode=0 shall go to channel sel if sel<N, regardless of in_valid[sel]; no grant otherwise.
REQ-018 Grant in mode=1 shall go to the first channel with in_valid set, searching from ptr upward modulo N.
REQ-019 in_ready[g] shall be high only for the granted channel g, and only when load=1 (combinational).
REQ-020 A transfer shall occur on channel g when in_valid[g] & in_ready[g]; on that edge out_data<=in_data[g], out_ch<=g, out_valid<=1.
REQ-021 Latency from input transfer to out_valid shall be exactly 1 cycle; throughput shall be 1 word per cycle when out_ready is held high.
REQ-022 When out_valid & out_ready and no input transfer occurs on the same edge, out_valid shall clear to 0.
REQ-023 While out_valid=1 & out_ready=0, out_data and out_ch shall hold stable and all in_ready bits shall be 0.
REQ-024 Round-robin pointer ptr (SEL_W bits) shall update to (g+1) mod N only on a mode=1 transfer; wrap from N-1 to 0.
REQ-025 With no in_valid bits set in mode=1, no grant shall occur and ptr shall hold.
REQ-026 Transfers in mode=0 shall not modify ptr.
REQ-027 A change of mode shall take effect in the same cycle; ptr shall retain its value across mode changes.
REQ-028 sel_err shall assert for one cycle after each cycle in which mode=0 and sel>=N; no transfer shall occur in that cycle.
REQ-029 For non-power-of-two N, search indices >=N shall be skipped.

Reset
REQ-030 While rst=1, out_valid=0, out_data=0, out_ch=0, ptr=0, sel_err=0 shall be forced on the next edge.
REQ-031 in_ready shall be all 0 in any cycle in which rst=1.
REQ-032 Reset asserted mid-stream shall discard the held output word; no transfer shall be reported for that word.

Verification
REQ-033 mode=0, sel=2, in_valid=4'b0100, ch2=0xA5A5A5A5, out_ready=1 -> next cycle out_valid=1, out_data=0xA5A5A5A5, out_ch=2.
REQ-034 mode=1, all in_valid=1 for 8 cycles, out_ready=1 -> out_ch sequence 0,1,2,3,0,1,2,3 with no gaps.
REQ-035 Backpressure: out_valid=1 and out_ready=0 for 3 cycles -> out_data stable, in_ready=0; then out_ready=1 -> the next word follows with no bubble.
REQ-036 N=3, mode=0, sel=3 -> sel_err pulses high 1 cycle, in_ready=0, out_valid unchanged.
REQ-037 mode=1, only ch1 valid, ptr=2 -> grant ch1 (wrap), ptr becomes 2.
REQ-038 rst asserted while out_valid=1 -> next cycle out_valid=0, out_data=0, ptr=0.
